ordering_stream_ctrl: RTL and testbench

Host-side bridge between the 8-city-per-beat ordering stream (`ordering_write`/`ordering_read`/`ordering_ready`, 8×8-bit data) and the per-replica ordering RAM inside `top`.
- Writes: unpacks each host beat into single-city RAM writes.
- Reads: fetches single cities and packs them into beats.
- Tracks which replica and city position the next beat belongs to, so the host can stream whole tours without addressing.

---
 rtl/ordering_stream_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ordering_stream_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ordering_stream_ctrl.sv
// ordering_stream_ctrl: bridges the 8-city-per-beat host ordering stream to
// the per-replica ordering RAM. Write beats are unpacked into single-city RAM
// writes and read beats are packed from single-city RAM reads. Replica and
// city position are tracked internally so the host streams whole tours.
module ordering_stream_ctrl #(
   parameter int ncity        = 31,
   parameter int replica_num  = 32,
   parameter int city_num_log = $clog2(ncity),
   parameter int replica_log  = $clog2(replica_num)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ordering_write,
   input  logic [7:0][7:0]         ordering_wdata,
   input  logic                    ordering_read,
   output logic [7:0][7:0]         ordering_rdata,
   output logic                    ordering_ready,
   output logic                    ram_we,
   output logic                    ram_re,
   output logic [replica_log-1:0]  ram_replica,
   output logic [city_num_log-1:0] ram_addr,
   output logic [7:0]              ram_wdata,
   input  logic [7:0]              ram_rdata,
   output logic                    busy
);

   // Every replica is sent as ncity/8+1 beats; slots at or beyond ncity are padding.
   localparam int BEATS = ncity / 8 + 1;
   localparam int SLOTS = BEATS * 8;
   localparam int EW    = $clog2(SLOTS + 1);

   localparam logic [EW-1:0]          NCITY_E   = EW'(ncity);
   localparam logic [EW-1:0]          LAST_SLOT = EW'(SLOTS - 1);
   localparam logic [replica_log-1:0] LAST_REP  = replica_log'(replica_num - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_LAST
   } state_e;

   typedef enum logic {
      DIR_WR,
      DIR_RD
   } dir_e;

   state_e                  state_q;
   dir_e                    dir_q;
   logic [2:0]              k_q;
   logic [EW-1:0]           elem_q;
   logic [replica_log-1:0]  rep_q;
   logic [7:0][7:0]         wbuf_q;
   logic [7:0][7:0]         rbuf_q;
   logic                    prev_re_q;

   logic [7:0][7:0]         ordering_rdata_q;
   logic                    ordering_ready_q;
   logic                    ram_we_q;
   logic                    ram_re_q;
   logic [7:0]              ram_wdata_q;

   logic                    dir_change;
   logic [EW-1:0]           elem_start;
   logic [replica_log-1:0]  rep_start;
   logic [EW-1:0]           elem_inc;
   logic [EW-1:0]           elem_after;
   logic [replica_log-1:0]  rep_after;
   logic [7:0]              rd_slot;

   // Start position of a new beat, next slot, and the pointer after a finished beat.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      dir_change = 1'b0;
      elem_start = elem_q;
      rep_start  = rep_q;
      elem_after = elem_q + EW'(1);
      rep_after  = rep_q;
      if (ordering_write) begin
         dir_change = (dir_q != DIR_WR);
      end else if (ordering_read) begin
         dir_change = (dir_q != DIR_RD);
      end
      if (dir_change) begin
         elem_start = '0;
         rep_start  = '0;
      end
      if (elem_q == LAST_SLOT) begin
         elem_after = '0;
         rep_after  = (rep_q == LAST_REP) ? '0 : rep_q + replica_log'(1);
      end
   end

   assign elem_inc = elem_q + EW'(1);

   // Padding slots were never read from RAM and return zero.
   assign rd_slot = prev_re_q ? ram_rdata : 8'h00;

   // Beat sequencer: owns all pointers, buffers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         dir_q            <= DIR_WR;
         k_q              <= '0;
         elem_q           <= '0;
         rep_q            <= '0;
         // NOTE: the beat buffers are a handful of flops, so they are reset
         // along with everything else rather than left as uninitialised storage.
         wbuf_q           <= '0;
         rbuf_q           <= '0;
         prev_re_q        <= 1'b0;
         ordering_rdata_q <= '0;
         ordering_ready_q <= 1'b0;
         ram_we_q         <= 1'b0;
         ram_re_q         <= 1'b0;
         ram_wdata_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every term on the right
         // is the pre-edge value and the defaults below can be overridden later.
         ordering_ready_q <= 1'b0;
         prev_re_q        <= ram_re_q;
         unique case (state_q)
            S_IDLE: begin
               if (ordering_ready_q) begin
                  // Give the host one cycle to react to a read pulse before restarting.
               end else if (ordering_write) begin
                  wbuf_q      <= ordering_wdata;
                  k_q         <= '0;
                  elem_q      <= elem_start;
                  rep_q       <= rep_start;
                  dir_q       <= DIR_WR;
                  ram_we_q    <= (elem_start < NCITY_E);
                  ram_wdata_q <= ordering_wdata[7];
                  state_q     <= S_WR;
               end else if (ordering_read) begin
                  k_q      <= '0;
                  elem_q   <= elem_start;
                  rep_q    <= rep_start;
                  dir_q    <= DIR_RD;
                  ram_re_q <= (elem_start < NCITY_E);
                  state_q  <= S_RD;
               end else begin
                  elem_q <= '0;
               end
            end
            S_WR: begin
               if (k_q == 3'd7) begin
                  ram_we_q <= 1'b0;
                  elem_q   <= elem_after;
                  rep_q    <= rep_after;
                  state_q  <= S_IDLE;
               end else begin
                  k_q              <= k_q + 3'd1;
                  elem_q           <= elem_inc;
                  ram_we_q         <= (elem_inc < NCITY_E);
                  ram_wdata_q      <= wbuf_q[3'd6 - k_q];
                  ordering_ready_q <= (k_q == 3'd6);
               end
            end
            S_RD: begin
               if (k_q != 3'd0) begin
                  rbuf_q[3'd7 - (k_q - 3'd1)] <= rd_slot;
               end
               if (k_q == 3'd7) begin
                  ram_re_q <= 1'b0;
                  elem_q   <= elem_after;
                  rep_q    <= rep_after;
                  state_q  <= S_RD_LAST;
               end else begin
                  k_q      <= k_q + 3'd1;
                  elem_q   <= elem_inc;
                  ram_re_q <= (elem_inc < NCITY_E);
               end
            end
            S_RD_LAST: begin
               ordering_rdata_q <= {rbuf_q[7:1], rd_slot};
               ordering_ready_q <= 1'b1;
               state_q          <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ordering_rdata = ordering_rdata_q;
   assign ordering_ready = ordering_ready_q;
   assign ram_we         = ram_we_q;
   assign ram_re         = ram_re_q;
   assign ram_wdata      = ram_wdata_q;
   assign ram_replica    = rep_q;
   assign ram_addr       = elem_q[city_num_log-1:0];
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ordering_stream_ctrl.sv
// Directed bench for ordering_stream_ctrl with a behavioural ordering RAM.
module tb_ordering_stream_ctrl;

   localparam int NCITY = 31;
   localparam int NREP  = 32;
   localparam int CL    = $clog2(NCITY);
   localparam int RL    = $clog2(NREP);

   logic            clk;
   logic            reset;
   logic            ordering_write;
   logic [7:0][7:0] ordering_wdata;
   logic            ordering_read;
   logic [7:0][7:0] ordering_rdata;
   logic            ordering_ready;
   logic            ram_we;
   logic            ram_re;
   logic [RL-1:0]   ram_replica;
   logic [CL-1:0]   ram_addr;
   logic [7:0]      ram_wdata;
   logic [7:0]      ram_rdata;
   logic            busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [RL-1:0] rep;
      logic [CL-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t             wr_log[$];
   int              rdy_log[$];
   logic [7:0][7:0] wq[$];
   logic [7:0][7:0] rd_beats[$];
   logic [7:0]      mem [0:NREP-1][0:(1<<CL)-1];

   ordering_stream_ctrl #(
      .ncity       (NCITY),
      .replica_num (NREP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ordering_write (ordering_write),
      .ordering_wdata (ordering_wdata),
      .ordering_read  (ordering_read),
      .ordering_rdata (ordering_rdata),
      .ordering_ready (ordering_ready),
      .ram_we         (ram_we),
      .ram_re         (ram_re),
      .ram_replica    (ram_replica),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ordering RAM: synchronous write, read data valid the cycle after ram_re.
   always @(posedge clk) begin
      if (ram_we) mem[ram_replica][ram_addr] <= ram_wdata;
      ram_rdata <= ram_re ? mem[ram_replica][ram_addr] : 8'hEE;
   end

   // Event monitor sampled mid-cycle.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (ram_we) wr_log.push_back({ram_replica, ram_addr, ram_wdata});
      if (ordering_ready) rdy_log.push_back(cyc);
   end

   function automatic logic [7:0] perm(input int t, input int p);
      return (t == 0) ? 8'((p * 3) % 31) : 8'((31 - p) % 31);
   endfunction

   function automatic logic [7:0] tval(input int n, input int p);
      return 8'((n * 31 + p) % 251);
   endfunction

   task automatic apply_reset();
      ordering_write = 1'b0;
      ordering_read  = 1'b0;
      ordering_wdata = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Streams every beat in wq; returns at the negedge where the last ready was seen.
   task automatic write_stream(input bit drop_at_end);
      int  n;
      bit  seen;
      n = wq.size();
      for (int b = 0; b < n; b++) begin
         ordering_write = 1'b1;
         ordering_wdata = wq[b];
         seen = 1'b0;
         for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            if (ordering_ready) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL write_ready beat %0d: no ordering_ready within 20 cycles, required one", b);
         end
      end
      if (drop_at_end) ordering_write = 1'b0;
      wq.delete();
   endtask

   task automatic read_stream(input int n);
      bit seen;
      for (int b = 0; b < n; b++) begin
         ordering_read = 1'b1;
         seen = 1'b0;
         for (int w = 0; w < 30 && !seen; w++) begin
            @(negedge clk);
            if (ordering_ready) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL read_ready beat %0d: no ordering_ready within 30 cycles, required one", b);
         end
         rd_beats.push_back(ordering_rdata);
      end
      ordering_read = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (ordering_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ordering_ready); end
      checks++; if (ordering_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ordering_rdata); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", ram_we); end
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b want 0", ram_re); end
      checks++; if (ram_replica !== '0) begin errors++; $display("FAIL reset_replica: got %0d want 0", ram_replica); end
      checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
      checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 0", ram_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_tour();
      logic [7:0][7:0] beat;
      wr_t             exp_e;
      apply_reset();
      wr_log.delete();
      rdy_log.delete();
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 8; j++) beat[7-j] = (8*b + j < NCITY) ? 8'(8*b + j) : 8'h00;
         wq.push_back(beat);
      end
      write_stream(1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_log.size() != 31) begin
         errors++; $display("FAIL tour_we_count: got %0d want 31", wr_log.size());
      end
      for (int i = 0; i < 31 && i < wr_log.size(); i++) begin
         exp_e.rep = '0; exp_e.addr = CL'(i); exp_e.data = 8'(i);
         checks++;
         if (wr_log[i] !== exp_e) begin
            errors++; $display("FAIL tour_write[%0d]: got %h want %h", i, wr_log[i], exp_e);
         end
      end
      checks++;
      if (rdy_log.size() != 4) begin
         errors++; $display("FAIL tour_ready_count: got %0d want 4", rdy_log.size());
      end
      for (int i = 1; i < 4 && i < rdy_log.size(); i++) begin
         checks++;
         if (rdy_log[i] - rdy_log[i-1] != 9) begin
            errors++; $display("FAIL tour_ready_gap[%0d]: got %0d want 9", i, rdy_log[i] - rdy_log[i-1]);
         end
      end
   endtask

   task automatic test_round_trip();
      logic [7:0][7:0] beat;
      logic [7:0][7:0] exp_b;
      int              pos;
      apply_reset();
      for (int t = 0; t < 2; t++) begin
         for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) beat[7-j] = (8*b + j < NCITY) ? perm(t, 8*b + j) : 8'h00;
            wq.push_back(beat);
         end
      end
      write_stream(1'b0);
      ordering_write = 1'b0;
      rd_beats.delete();
      rdy_log.delete();
      read_stream(8);
      repeat (3) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 8; j++) begin
            pos = 8*(b % 4) + j;
            exp_b[7-j] = (pos < NCITY) ? perm(b / 4, pos) : 8'h00;
         end
         checks++;
         if (rd_beats[b] !== exp_b) begin
            errors++; $display("FAIL trip_beat[%0d]: got %h want %h", b, rd_beats[b], exp_b);
         end
      end
      checks++;
      if (rdy_log.size() < 2 || rdy_log[1] - rdy_log[0] != 11) begin
         errors++; $display("FAIL trip_read_gap: got %0d readies, gap %0d, want gap 11",
                            rdy_log.size(), (rdy_log.size() < 2) ? 0 : rdy_log[1] - rdy_log[0]);
      end
   endtask

   task automatic test_replica_wrap();
      logic [7:0][7:0] beat;
      wr_t             exp_e;
      apply_reset();
      wr_log.delete();
      for (int n = 0; n <= NREP; n++) begin
         for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) beat[7-j] = (8*b + j < NCITY) ? tval(n, 8*b + j) : 8'h00;
            wq.push_back(beat);
         end
      end
      write_stream(1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_log.size() != (NREP + 1) * 31) begin
         errors++; $display("FAIL wrap_count: got %0d want %0d", wr_log.size(), (NREP + 1) * 31);
      end
      exp_e.rep = '0; exp_e.addr = '0; exp_e.data = tval(NREP, 0);
      checks++;
      if (wr_log[NREP*31] !== exp_e) begin
         errors++; $display("FAIL wrap_first: got %h want %h", wr_log[NREP*31], exp_e);
      end
      exp_e.rep = '0; exp_e.addr = CL'(30); exp_e.data = tval(NREP, 30);
      checks++;
      if (wr_log[NREP*31 + 30] !== exp_e) begin
         errors++; $display("FAIL wrap_last: got %h want %h", wr_log[NREP*31 + 30], exp_e);
      end
      checks++;
      if (wr_log[(NREP-1)*31].rep !== RL'(NREP - 1)) begin
         errors++; $display("FAIL wrap_rep31: got %0d want %0d", wr_log[(NREP-1)*31].rep, NREP - 1);
      end
      checks++;
      if (mem[0][5] !== tval(NREP, 5)) begin
         errors++; $display("FAIL wrap_mem0: got %h want %h", mem[0][5], tval(NREP, 5));
      end
      checks++;
      if (mem[1][5] !== tval(1, 5)) begin
         errors++; $display("FAIL wrap_mem1: got %h want %h", mem[1][5], tval(1, 5));
      end
      checks++;
      if (mem[NREP-1][30] !== tval(NREP - 1, 30)) begin
         errors++; $display("FAIL wrap_mem31: got %h want %h", mem[NREP-1][30], tval(NREP - 1, 30));
      end
   endtask

   task automatic test_abandon();
      logic [7:0][7:0] beat;
      wr_t             exp_e;
      apply_reset();
      for (int b = 0; b < 2; b++) begin
         for (int j = 0; j < 8; j++) beat[7-j] = 8'(8'hA0 + 8*b + j);
         wq.push_back(beat);
      end
      write_stream(1'b1);
      repeat (2) @(negedge clk);
      wr_log.delete();
      for (int j = 0; j < 8; j++) beat[7-j] = 8'(8'hC0 + j);
      wq.push_back(beat);
      write_stream(1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_log.size() != 8) begin
         errors++; $display("FAIL abandon_count: got %0d want 8", wr_log.size());
      end
      for (int j = 0; j < 8 && j < wr_log.size(); j++) begin
         exp_e.rep = '0; exp_e.addr = CL'(j); exp_e.data = 8'(8'hC0 + j);
         checks++;
         if (wr_log[j] !== exp_e) begin
            errors++; $display("FAIL abandon_write[%0d]: got %h want %h", j, wr_log[j], exp_e);
         end
      end
      checks++;
      if (mem[0][9] !== 8'hA9) begin
         errors++; $display("FAIL abandon_keep: got %h want a9", mem[0][9]);
      end
   endtask

   task automatic test_priority_drop();
      bit seen;
      apply_reset();
      wr_log.delete();
      rdy_log.delete();
      for (int j = 0; j < 8; j++) ordering_wdata[7-j] = 8'(8'h50 + j);
      ordering_write = 1'b1;
      ordering_read  = 1'b1;
      @(negedge clk);
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL prio_we: got %b want 1", ram_we); end
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL prio_re: got %b want 0", ram_re); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b want 1", busy); end
      ordering_read = 1'b0;
      repeat (3) @(negedge clk);
      ordering_write = 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
         @(negedge clk);
         if (ordering_ready) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL prio_ready: no ordering_ready within 10 cycles, required one"); end
      repeat (3) @(negedge clk);
      checks++; if (wr_log.size() != 8) begin errors++; $display("FAIL prio_count: got %0d want 8", wr_log.size()); end
      checks++; if (rdy_log.size() != 1) begin errors++; $display("FAIL prio_ready_count: got %0d want 1", rdy_log.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", busy); end
      checks++; if (mem[0][7] !== 8'h57) begin errors++; $display("FAIL prio_mem: got %h want 57", mem[0][7]); end
   endtask

   task automatic test_reset_mid_read();
      bit seen;
      apply_reset();
      ordering_read = 1'b1;
      seen = 1'b0;
      for (int w = 0; w < 30 && !seen; w++) begin
         @(negedge clk);
         if (ordering_ready) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_first_beat: no ordering_ready within 30 cycles, required one"); end
      repeat (6) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
      checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL rst_pre_re: got %b want 1", ram_re); end
      checks++; if (ram_addr !== CL'(12)) begin errors++; $display("FAIL rst_pre_addr: got %0d want 12", ram_addr); end
      reset = 1'b0;
      #1;
      checks++; if (ordering_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ordering_ready); end
      checks++; if (ordering_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", ordering_rdata); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", ram_we); end
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_re: got %b want 0", ram_re); end
      checks++; if (ram_replica !== '0) begin errors++; $display("FAIL rst_replica: got %0d want 0", ram_replica); end
      checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d want 0", ram_addr); end
      checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(negedge clk);
      checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_held_re: got %b want 0", ram_re); end
      ordering_read = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      ordering_read = 1'b1;
      @(negedge clk);
      checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL rst_fresh_re: got %b want 1", ram_re); end
      checks++; if (ram_replica !== '0) begin errors++; $display("FAIL rst_fresh_replica: got %0d want 0", ram_replica); end
      checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_fresh_addr: got %0d want 0", ram_addr); end
      seen = 1'b0;
      for (int w = 0; w < 30 && !seen; w++) begin
         @(negedge clk);
         if (ordering_ready) seen = 1'b1;
      end
      ordering_read = 1'b0;
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_fresh_ready: no ordering_ready within 30 cycles, required one"); end
   endtask

   initial begin
      reset          = 1'b1;
      ordering_write = 1'b0;
      ordering_read  = 1'b0;
      ordering_wdata = '0;
      test_reset();
      test_write_tour();
      test_round_trip();
      test_replica_wrap();
      test_abandon();
      test_priority_drop();
      test_reset_mid_read();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
